ifu_fetch: RTL and testbench

- Instruction fetch stage that owns the PC and produces one instruction at a time for the single-cycle core's decode/execute datapath.
- Replaces the zero-latency instruction RAM port with an AXI4-Lite read-only master, so fetch latency can vary.
- Presents {pc, inst, exc} to the core over a valid/ready handshake.
- Accepts redirects (jump, exception entry, mret) from the core's next-PC logic.

---
 rtl/ifu_pkg.sv | 22 ++
 rtl/ifu_fetch.sv | 137 +++++++++++++
 tb/tb_ifu_fetch.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUSERR   = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // A fetch address is usable only when it is 32-bit word aligned.
  function automatic logic word_aligned(input logic [1:0] lo);
    return lo == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over an
// AXI4-Lite read-only master and presents {pc, inst, exc} over valid/ready.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned     AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_pc,
  output logic [31:0]   out_inst,
  output logic [1:0]    out_exc,
  output logic [AW-1:0] araddr,
  output logic          arvalid,
  input  logic          arready,
  input  logic [31:0]   rdata,
  input  logic [1:0]    rresp,
  input  logic          rvalid,
  output logic          rready
);

  ifu_state_e    state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_req;
  logic          drop;

  logic [AW-1:0] fetch_target;
  logic [AW-1:0] pc_inc;

  // PC to fetch next when leaving IDLE or abandoning a beat: a redirect wins.
  assign fetch_target = redirect_valid ? redirect_pc : pc;
  assign pc_inc       = pc + AW'(4);
  assign araddr       = pc_req;

  // Fetch FSM with PC, request address, drop flag and registered outputs.
  // pc tracks the architectural fetch PC at all times; pc_req only changes
  // when a new request is started, so araddr stays stable across redirects
  // and the in-flight beat is discarded via drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      pc_req    <= RESET_PC;
      drop      <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_exc   <= EXC_NONE;
      out_pc    <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          pc      <= fetch_target;
          pc_req  <= fetch_target;
          drop    <= 1'b0;
          arvalid <= word_aligned(fetch_target[1:0]);
          state   <= ADDR;
        end

        ADDR: begin
          if (!word_aligned(pc_req[1:0])) begin
            // No AR is ever issued for a misaligned PC.
            if (redirect_valid) begin
              pc      <= redirect_pc;
              pc_req  <= redirect_pc;
              drop    <= 1'b0;
              arvalid <= word_aligned(redirect_pc[1:0]);
            end else begin
              out_inst  <= '0;
              out_exc   <= EXC_MISALIGN;
              out_pc    <= pc_req;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end else begin
            if (redirect_valid) begin
              pc   <= redirect_pc;
              drop <= 1'b1;
            end
            if (arready) begin
              arvalid <= 1'b0;
              rready  <= 1'b1;
              state   <= DATA;
            end
          end
        end

        DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (drop || redirect_valid) begin
              pc      <= fetch_target;
              pc_req  <= fetch_target;
              drop    <= 1'b0;
              arvalid <= word_aligned(fetch_target[1:0]);
              state   <= ADDR;
            end else begin
              out_inst  <= rdata;
              out_exc   <= (rresp != AXI_RESP_OKAY) ? EXC_BUSERR : EXC_NONE;
              out_pc    <= pc;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_pc;
            drop <= 1'b1;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            pc        <= redirect_pc;
            pc_req    <= redirect_pc;
            out_valid <= 1'b0;
            arvalid   <= word_aligned(redirect_pc[1:0]);
            state     <= ADDR;
          end else if (out_ready) begin
            pc        <= pc_inc;
            pc_req    <= pc_inc;
            out_valid <= 1'b0;
            arvalid   <= word_aligned(pc_inc[1:0]);
            state     <= ADDR;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: AXI4-Lite memory model plus an
// architectural-PC reference model, directed steps then randomized traffic.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  out_exc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  ifu_fetch #(.AW(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int errors = 0;

  // memory configuration
  bit          cfg_rand = 1'b0;
  int          cfg_ar_fix = 0;
  int          cfg_r_fix = 0;
  int          cfg_max = 3;
  bit          fixed13 = 1'b0;
  bit          poison_en = 1'b0;
  logic [31:0] poison_addr = '0;

  // memory state
  bit          mem_busy = 1'b0;
  bit          ar_armed = 1'b0;
  int          ar_wait = 0;
  int          r_wait = 0;
  logic [31:0] mem_addr = '0;
  logic [31:0] ar_log[$];

  // reference model: architectural fetch PC
  logic [31:0] model_pc = RST_PC;

  // previous-cycle observations
  bit          p_valid = 0, p_ready = 0, p_redir = 0, p_arv = 0, p_ary = 0, p_rst = 0;
  logic [31:0] p_pc = '0, p_inst = '0, p_araddr = '0;
  logic [1:0]  p_exc = '0;
  int          since_valid = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (poison_en && a == poison_addr) return 32'hDEAD_BEEF;
    if (fixed13) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic bit buserr(input logic [31:0] a);
    return a[7:4] == 4'hE;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 32'h0;
    return data_of(a);
  endfunction

  function automatic logic [1:0] exp_exc(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if (buserr(a)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int pick(input int fix);
    if (cfg_rand) return int'($urandom_range(0, cfg_max));
    return fix;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: observe/check at negedge, drive memory, advance model.
  task automatic step();
    bit hs_ar, hs_r;
    logic [31:0] nxt;
    hs_ar = 0; hs_r = 0; nxt = model_pc;
    if (rst) begin
      if (out_valid) begin
        chk("out_pc", out_pc, model_pc);
        chk("out_inst", out_inst, exp_inst(model_pc));
        chk("out_exc", 32'(out_exc), 32'(exp_exc(model_pc)));
        since_valid = 0;
      end else begin
        since_valid++;
      end
      if (p_rst && p_valid && !p_ready && !p_redir) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_pc", out_pc, p_pc);
        chk("hold_inst", out_inst, p_inst);
        chk("hold_exc", 32'(out_exc), 32'(p_exc));
      end
      if (p_rst && p_arv && !p_ary) begin
        chk("ar_keep_valid", 32'(arvalid), 32'd1);
        chk("ar_keep_addr", araddr, p_araddr);
      end
      if (arvalid) begin
        chk("ar_aligned", 32'(araddr[1:0]), 32'd0);
        chk("one_outstanding", 32'(mem_busy), 32'd0);
        if (!ar_armed) begin
          ar_wait  = pick(cfg_ar_fix);
          ar_armed = 1;
        end
        arready = (ar_wait == 0);
        if (ar_wait > 0) ar_wait--;
      end else begin
        arready = 1'b0;
      end
      if (mem_busy && r_wait == 0) begin
        rvalid = 1'b1;
        rdata  = data_of(mem_addr);
        rresp  = buserr(mem_addr) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = '0;
        if (mem_busy) r_wait--;
      end
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      if (redirect_valid) nxt = redirect_pc;
      else if (out_valid && out_ready) nxt = model_pc + 32'd4;
    end else begin
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = '0;
      rresp   = '0;
    end
    p_valid = out_valid; p_ready = out_ready; p_redir = redirect_valid;
    p_arv = arvalid; p_ary = arready; p_rst = rst;
    p_pc = out_pc; p_inst = out_inst; p_exc = out_exc; p_araddr = araddr;
    @(posedge clk);
    if (rst) begin
      if (hs_r) mem_busy = 1'b0;
      if (hs_ar) begin
        mem_busy = 1'b1;
        mem_addr = p_araddr;
        ar_armed = 1'b0;
        r_wait   = pick(cfg_r_fix);
        ar_log.push_back(p_araddr);
      end
      model_pc = nxt;
    end
    @(negedge clk);
  endtask

  // Step until out_valid is seen at a negedge, bounded by maxc cycles.
  task automatic run_until_valid(input int maxc, output int n);
    n = 0;
    while (!out_valid && n < maxc) begin
      step();
      n++;
    end
    chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    int ar_n;
    logic [31:0] h_pc, h_inst, old;
    logic [1:0]  h_exc;

    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);

    // reset state
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_exc", 32'(out_exc), 32'd0);
    chk("rst_out_pc", out_pc, RST_PC);
    chk("rst_araddr", araddr, RST_PC);

    // zero-wait memory returning 0x13, core always ready
    fixed13 = 1'b1;
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    chk("first_arvalid", 32'(arvalid), 32'd1);
    chk("first_araddr", araddr, RST_PC);
    run_until_valid(20, n);
    chk("first_latency", 32'(n), 32'd2);
    chk("first_pc", out_pc, RST_PC);
    chk("first_inst", out_inst, 32'h13);
    step();
    run_until_valid(20, n);
    chk("throughput_gap", 32'(n + 1), 32'd3);
    chk("second_pc", out_pc, RST_PC + 32'd4);

    // consumer stalls 5 cycles in HOLD
    out_ready = 1'b0;
    h_pc = out_pc; h_inst = out_inst; h_exc = out_exc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc", out_pc, h_pc);
      chk("stall_inst", out_inst, h_inst);
      chk("stall_exc", 32'(out_exc), 32'(h_exc));
      chk("stall_no_ar", 32'(arvalid), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("release_arvalid", 32'(arvalid), 32'd1);
    chk("release_araddr", araddr, h_pc + 32'd4);
    fixed13 = 1'b0;

    // redirect while in DATA; delayed beat must be discarded
    cfg_r_fix = 2;
    step();
    chk("data_rready", 32'(rready), 32'd1);
    poison_addr = mem_addr;
    poison_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    ar_n = ar_log.size();
    step();
    redirect_valid = 1'b0;
    cfg_r_fix = 0;
    run_until_valid(30, n);
    chk("data_redir_pc", out_pc, 32'h8000_0100);
    chk("data_redir_ar_count", 32'(ar_log.size()), 32'(ar_n + 1));
    chk("data_redir_ar_addr", ar_log[ar_log.size() - 1], 32'h8000_0100);
    poison_en = 1'b0;

    // redirect while AR is pending with arready low for 3 cycles
    cfg_ar_fix = 3;
    step();
    old = araddr;
    chk("pend_old_addr", old, 32'h8000_0104);
    chk("pend_arvalid", 32'(arvalid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    ar_n = ar_log.size();
    step();
    redirect_valid = 1'b0;
    cfg_ar_fix = 0;
    for (int i = 0; i < 2; i++) begin
      chk("pend_keep_valid", 32'(arvalid), 32'd1);
      chk("pend_keep_addr", araddr, old);
      step();
    end
    run_until_valid(30, n);
    chk("pend_ar_count", 32'(ar_log.size()), 32'(ar_n + 2));
    chk("pend_ar_first", ar_log[ar_n], old);
    chk("pend_ar_second", ar_log[ar_n + 1], 32'h8000_0200);
    chk("pend_out_pc", out_pc, 32'h8000_0200);

    // bus error; redirect beats out_ready in HOLD
    redirect_valid = 1'b1; redirect_pc = 32'h8000_00E0;
    step();
    redirect_valid = 1'b0;
    run_until_valid(20, n);
    chk("buserr_exc", 32'(out_exc), 32'd2);
    chk("buserr_pc", out_pc, 32'h8000_00E0);

    // PC wrap at top of address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    run_until_valid(20, n);
    chk("wrap_top_pc", out_pc, 32'hFFFF_FFFC);
    step();
    run_until_valid(20, n);
    chk("wrap_zero_pc", out_pc, 32'h0000_0000);

    // misaligned target: no AR, exception presented
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    ar_n = ar_log.size();
    step();
    redirect_valid = 1'b0;
    run_until_valid(20, n);
    chk("misalign_no_ar", 32'(ar_log.size()), 32'(ar_n));
    chk("misalign_exc", 32'(out_exc), 32'd1);
    chk("misalign_inst", out_inst, 32'd0);
    chk("misalign_pc", out_pc, 32'h8000_0102);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    step();
    redirect_valid = 1'b0;
    run_until_valid(20, n);
    chk("after_misalign_pc", out_pc, 32'h8000_0300);

    // asynchronous reset in the middle of DATA
    cfg_r_fix = 3;
    step();
    step();
    chk("pre_rst_rready", 32'(rready), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_arvalid", 32'(arvalid), 32'd0);
    chk("async_rready", 32'(rready), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_araddr", araddr, RST_PC);
    chk("async_out_pc", out_pc, RST_PC);
    mem_busy = 1'b0; ar_armed = 1'b0; ar_wait = 0; r_wait = 0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    model_pc = RST_PC; since_valid = 0;
    p_valid = 0; p_arv = 0; p_rst = 0;
    cfg_r_fix = 0;
    @(negedge clk);
    step();
    rst = 1'b1;
    run_until_valid(20, n);
    chk("restart_pc", out_pc, RST_PC);

    // randomized traffic against the architectural model
    cfg_rand = 1'b1;
    cfg_max = 3;
    for (int i = 0; i < 600; i++) begin
      int r;
      out_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = (since_valid < 20) && ($urandom_range(0, 99) < 8);
      r = int'($urandom_range(0, 9));
      if (r < 6)
        redirect_pc = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
      else if (r < 8)
        redirect_pc = 32'h8000_00E0 | (32'($urandom_range(0, 15)) << 8)
                      | (32'($urandom_range(0, 3)) << 2);
      else
        redirect_pc = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2)
                      + 32'($urandom_range(1, 3));
      step();
      checks++;
      assert (since_valid <= 60) else begin
        errors++;
        $error("FAIL watchdog got=%0d exp<=60", since_valid);
      end
    end
    redirect_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
